pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer_pkg.sv | 15 +
 rtl/step_timer.sv | 30 +++
 rtl/pattern_sequencer.sv | 142 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sequencer_pkg.sv
// Shared types for the pattern sequencer: FSM state encoding and mode codes.
package pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Mode codes; 2'b11 is not listed and behaves like LOOP.
    localparam logic [1:0] ONE_SHOT = 2'b00;
    localparam logic [1:0] LOOP     = 2'b01;
    localparam logic [1:0] BOUNCE   = 2'b10;

endpackage

// File: rtl/step_timer.sv
// Step prescaler: counts 0..div while run is high and flags the terminal
// count with tick, then wraps to 0. Holding run low freezes the count.
module step_timer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Terminal count is combinational so the owner can act on it this cycle.
    assign tick = run && (cnt == div);

    // Count register: clear wins over run; frozen while run is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: walks an external ROM address in one-shot, loop or
// bounce order at a programmable step rate and drives the ROM data to led.
// The ROM has one clock of read latency, so every address load is tracked
// through a two-stage flag and led updates two clocks after addr changes.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MEM_ADDR = 3,
    parameter int DIV_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    step_div,
    output logic [MEM_ADDR-1:0] addr,
    input  logic [WIDTH-1:0]    rom_data,
    output logic [WIDTH-1:0]    led,
    output logic                busy,
    output logic                done,
    output logic [1:0]          dbg_state
);

    localparam logic [MEM_ADDR-1:0] ADDR_MAX = '1;

    state_t           state;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] div_q;
    logic             dir_down;
    logic             rd_req;   // addr was loaded last edge; ROM reads it now
    logic             rd_cap;   // ROM data for that load is on rom_data now
    logic             tick;
    logic             timer_clr;
    logic             timer_run;

    // Prescaler restarts on any start/stop and only advances in RUN.
    assign timer_clr = start | stop;
    assign timer_run = (state == ST_RUN);

    step_timer #(.DIV_W(DIV_W)) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .run   (timer_run),
        .div   (div_q),
        .tick  (tick)
    );

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Control FSM, address stepping and read-pipeline tracking; stop beats start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= ONE_SHOT;
            div_q    <= '0;
            addr     <= '0;
            dir_down <= 1'b0;
            done     <= 1'b0;
            rd_req   <= 1'b0;
            rd_cap   <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_req <= 1'b0;
            rd_cap <= rd_req;
            if (stop) begin
                state  <= ST_IDLE;
                rd_req <= 1'b0;
                rd_cap <= 1'b0;
            end else if (start) begin
                state    <= ST_RUN;
                mode_q   <= mode;
                div_q    <= step_div;
                addr     <= '0;
                dir_down <= 1'b0;
                rd_req   <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (!en) begin
                            state <= ST_PAUSE;
                        end
                        // A tick in the cycle en drops is still honoured.
                        if (tick) begin
                            if (mode_q == ONE_SHOT) begin
                                if (addr == ADDR_MAX) begin
                                    done  <= 1'b1;
                                    state <= ST_IDLE;
                                end else begin
                                    addr   <= addr + 1'b1;
                                    rd_req <= 1'b1;
                                end
                            end else if (mode_q == BOUNCE) begin
                                rd_req <= 1'b1;
                                if (!dir_down) begin
                                    if (addr == ADDR_MAX) begin
                                        addr     <= addr - 1'b1;
                                        dir_down <= 1'b1;
                                    end else begin
                                        addr <= addr + 1'b1;
                                    end
                                end else begin
                                    if (addr == '0) begin
                                        addr     <= addr + 1'b1;
                                        dir_down <= 1'b0;
                                    end else begin
                                        addr <= addr - 1'b1;
                                    end
                                end
                            end else begin
                                // LOOP and the unused code: natural wrap max->0.
                                addr   <= addr + 1'b1;
                                rd_req <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (en) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // LED register: capture ROM data when a tracked read lands, unless stopping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (rd_cap && !stop) begin
            led <= rom_data;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a 1-clock-latency ROM model.
module tb_pattern_sequencer;

    localparam int WIDTH    = 4;
    localparam int MEM_ADDR = 3;
    localparam int DIV_W    = 24;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                en = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic [DIV_W-1:0]    step_div = '0;
    logic [MEM_ADDR-1:0] addr;
    logic [WIDTH-1:0]    rom_data;
    logic [WIDTH-1:0]    led;
    logic                busy;
    logic                done;
    logic [1:0]          dbg_state;

    logic [WIDTH-1:0] rom [8];
    int               bseq [17];
    int checks = 0;
    int errors = 0;

    pattern_sequencer #(
        .WIDTH    (WIDTH),
        .MEM_ADDR (MEM_ADDR),
        .DIV_W    (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .mode      (mode),
        .step_div  (step_div),
        .addr      (addr),
        .rom_data  (rom_data),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // ROM model with one clock of read latency
    always @(posedge clk) rom_data <= rom[addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input int d);
        mode     = m;
        step_div = DIV_W'(d);
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (addr !== 3'd0 || led !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset: addr=%0d led=%b busy=%b done=%b st=%0d required 0 0000 0 0 0", addr, led, busy, done, dbg_state);
        end
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || addr !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b addr=%0d required 0 0", busy, addr);
        end
    endtask

    task automatic test_one_shot();
        int ea;
        do_start(2'b00, 0);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) step();
            ea = (k > 7) ? 7 : k;
            checks++;
            if (addr !== ea[2:0]) begin
                errors++;
                $display("FAIL one_shot_addr k=%0d got %0d required %0d", k, addr, ea);
            end
            checks++;
            if (done !== (k == 8) || busy !== (k <= 7)) begin
                errors++;
                $display("FAIL one_shot_flags k=%0d done=%b busy=%b required %b %b", k, done, busy, k == 8, k <= 7);
            end
            checks++;
            if (led !== ((k < 2) ? 4'b0000 : rom[k-2])) begin
                errors++;
                $display("FAIL one_shot_led k=%0d got %b required %b", k, led, (k < 2) ? 4'b0000 : rom[k-2]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (led !== 4'b0010 || addr !== 3'd7 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL one_shot_hold: led=%b addr=%0d done=%b busy=%b required 0010 7 0 0", led, addr, done, busy);
            end
        end
    endtask

    task automatic test_loop();
        int ea;
        do_start(2'b01, 3);
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) step();
            ea = (k / 4) % 8;
            checks++;
            if (addr !== ea[2:0] || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL loop_addr k=%0d addr=%0d done=%b busy=%b required %0d 0 1", k, addr, done, busy, ea);
            end
            if (k >= 2) begin
                checks++;
                if (led !== rom[((k - 2) / 4) % 8]) begin
                    errors++;
                    $display("FAIL loop_led k=%0d got %b required %b", k, led, rom[((k - 2) / 4) % 8]);
                end
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_bounce();
        do_start(2'b10, 0);
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            checks++;
            if (addr !== bseq[k][2:0]) begin
                errors++;
                $display("FAIL bounce_addr k=%0d got %0d required %0d", k, addr, bseq[k]);
            end
            if (k >= 2) begin
                checks++;
                if (led !== rom[bseq[k-2]]) begin
                    errors++;
                    $display("FAIL bounce_led k=%0d got %b required %b", k, led, rom[bseq[k-2]]);
                end
            end
        end
        // Stop while a capture is in flight: led must keep 0001.
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || led !== 4'b0001) begin
                errors++;
                $display("FAIL bounce_stop k=%0d busy=%b done=%b led=%b required 0 0 0001", k, busy, done, led);
            end
            step();
        end
    endtask

    task automatic test_pause();
        int ea;
        do_start(2'b01, 2);
        for (int k = 1; k <= 4; k++) begin
            step();
            ea = (k >= 3) ? 1 : 0;
            checks++;
            if (addr !== ea[2:0]) begin
                errors++;
                $display("FAIL pause_pre k=%0d addr=%0d required %0d", k, addr, ea);
            end
        end
        en = 1'b0;
        for (int k = 5; k <= 14; k++) begin
            step();
            checks++;
            if (addr !== 3'd1 || led !== 4'b0010 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold k=%0d addr=%0d led=%b busy=%b required 1 0010 1", k, addr, led, busy);
            end
            if (k == 6) begin
                checks++;
                if (dbg_state !== 2'd2) begin
                    errors++;
                    $display("FAIL pause_state got %0d required 2", dbg_state);
                end
            end
        end
        en = 1'b1;
        for (int k = 15; k <= 19; k++) begin
            step();
            ea = (k >= 19) ? 3 : ((k >= 16) ? 2 : 1);
            checks++;
            if (addr !== ea[2:0]) begin
                errors++;
                $display("FAIL pause_resume k=%0d addr=%0d required %0d", k, addr, ea);
            end
        end
        checks++;
        if (led !== 4'b0100) begin
            errors++;
            $display("FAIL pause_resume_led got %b required 0100", led);
        end
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || dbg_state !== 2'd0 || led !== 4'b0100 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_stop k=%0d busy=%b st=%0d led=%b done=%b required 0 0 0100 0", k, busy, dbg_state, led, done);
            end
            step();
        end
    endtask

    task automatic test_restart();
        do_start(2'b00, 0);
        step();
        step();
        step();
        checks++;
        if (addr !== 3'd3) begin
            errors++;
            $display("FAIL restart_pre addr=%0d required 3", addr);
        end
        // Restart mid-run with the unused mode code, which runs as a loop.
        do_start(2'b11, 0);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) step();
            checks++;
            if (addr !== 3'(k % 8) || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL restart_loop k=%0d addr=%0d done=%b busy=%b required %0d 0 1", k, addr, done, busy, k % 8);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_start(2'b00, 1);
        for (int k = 1; k <= 10; k++) step();
        checks++;
        if (addr !== 3'd5 || led !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid_pre addr=%0d led=%b required 5 0100", addr, led);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (addr !== 3'd0 || led !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async addr=%0d led=%b busy=%b done=%b required 0 0000 0 0", addr, led, busy, done);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (addr !== 3'd0 || led !== 4'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_idle k=%0d addr=%0d led=%b busy=%b required 0 0000 0", k, addr, led, busy);
            end
        end
    endtask

    initial begin
        rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;
        rom[4] = 4'b0100; rom[5] = 4'b0010; rom[6] = 4'b0001; rom[7] = 4'b0010;
        bseq = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        test_reset();
        test_one_shot();
        test_loop();
        test_bounce();
        test_pause();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
